perceptron_activation: RTL and testbench

Output stage of the single-perceptron datapath: sits directly downstream of the cascaded DSP48 weighted-sum stage. The weighted-sum stage has a fixed pipeline latency and no handshake, so this block tracks each input presentation through a matching valid-delay line, captures the 48-bit sum when it emerges, and applies a programmable threshold (step activation). Results are buffered in a 4-entry FIFO with a valid/ready interface, so a stalled consumer never blocks the free-running upstream pipeline.

---
 rtl/perceptron_activation.sv | 198 +++++++++++++++++++
 tb/tb_perceptron_activation.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_activation.sv
// -----------------------------------------------------------------------------
// perceptron_activation
//
// Output stage of the single-perceptron datapath. The upstream weighted-sum
// stage has a fixed latency and no handshake, so each input presentation is
// tracked through a valid delay line. When the matching sum emerges it is
// captured with a step-activation compare (sum >= threshold) and then pushed
// into a small result FIFO with a valid/ready read side. A stalled consumer
// never back-pressures the upstream pipeline; results arriving at a full FIFO
// are dropped and flagged.
//
// Parameters:
//   LATENCY      edges from in_valid sampled to the matching sum valid (>= 1)
//   THRESH_INIT  threshold value after reset
//   FIFO_DEPTH   result FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     vector presented to the weighted-sum stage this cycle
//   sum          48-bit unsigned weighted sum from the weighted-sum stage
//   thr_load     load thr_data into the threshold register
//   thr_data     new threshold, unsigned
//   out_valid    FIFO head holds a result
//   out_ready    consumer accepts the head this cycle
//   out_fire     head result: 1 if sum >= threshold
//   out_sum      head result: captured sum
//   fire_count   saturating count of accepted results with fire = 1
//   overflow     sticky: a result was dropped because the FIFO was full
//   busy         anything in flight in the delay line, capture stage or FIFO
// -----------------------------------------------------------------------------
module perceptron_activation #(
    parameter int unsigned LATENCY     = 11,
    parameter logic [47:0] THRESH_INIT = 48'd0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [47:0] sum,
    input  logic        thr_load,
    input  logic [47:0] thr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_fire,
    output logic [47:0] out_sum,
    output logic [15:0] fire_count,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Valid delay line
    // -------------------------------------------------------------------------
    logic [LATENCY-1:0] dly_q;
    logic [LATENCY-1:0] dly_d;
    logic [LATENCY:0]   dly_ext;
    logic               tap;

    // Extending by one bit and dropping the MSB keeps the shift expression
    // legal for LATENCY = 1 without a generate branch.
    always_comb begin
        dly_ext = {dly_q, in_valid};
        dly_d   = dly_ext[LATENCY-1:0];
    end

    // A bit entering at edge 0 reaches the top after edge LATENCY-1, so the
    // tap is high going into edge LATENCY, which is when sum is valid.
    assign tap = dly_q[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    // -------------------------------------------------------------------------
    // Threshold register
    // -------------------------------------------------------------------------
    logic [47:0] thr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q <= THRESH_INIT;
        end else if (thr_load) begin
            thr_q <= thr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Capture stage
    // -------------------------------------------------------------------------
    logic        cap_valid_q;
    logic        cap_fire_q;
    logic [47:0] cap_sum_q;

    // Compare uses thr_q as it stood before this edge, so a thr_load landing
    // on the same edge only affects later captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_fire_q  <= 1'b0;
            cap_sum_q   <= '0;
        end else begin
            cap_valid_q <= tap;
            if (tap) begin
                cap_fire_q <= (sum >= thr_q);
                cap_sum_q  <= sum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result FIFO
    // -------------------------------------------------------------------------
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        accept;
    logic        drop;

    logic        mem_fire [FIFO_DEPTH];
    logic [47:0] mem_sum  [FIFO_DEPTH];

    // Extra pointer MSB distinguishes full from empty.
    always_comb begin
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        push       = cap_valid_q;
        pop        = !fifo_empty && out_ready;
        // A pop on the same edge frees the slot the push needs.
        accept     = push && (!fifo_full || pop);
        drop       = push && fifo_full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (accept) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: contents are only observed while out_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_fire[wptr_q[AW-1:0]] <= cap_fire_q;
            mem_sum[wptr_q[AW-1:0]]  <= cap_sum_q;
        end
    end

    // Gate the head with out_valid so the outputs read zero out of reset.
    always_comb begin
        out_valid = !fifo_empty;
        out_fire  = out_valid & mem_fire[rptr_q[AW-1:0]];
        out_sum   = out_valid ? mem_sum[rptr_q[AW-1:0]] : '0;
    end

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    logic [15:0] fire_count_q;
    logic        overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (accept && cap_fire_q && (fire_count_q != 16'hFFFF)) begin
                fire_count_q <= fire_count_q + 16'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign fire_count = fire_count_q;
    assign overflow   = overflow_q;
    assign busy       = (|dly_q) | cap_valid_q | out_valid;

endmodule

// File: tb/tb_perceptron_activation.sv
module tb_perceptron_activation;

    localparam int unsigned L    = 11;
    localparam int unsigned D    = 4;
    localparam logic [47:0] THR0 = 48'd1000;
    localparam logic [47:0] MAXV = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MSB  = 48'h8000_0000_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [47:0] sum;
    logic        thr_load;
    logic [47:0] thr_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_fire;
    logic [47:0] out_sum;
    logic [15:0] fire_count;
    logic        overflow;
    logic        busy;

    perceptron_activation #(
        .LATENCY    (L),
        .THRESH_INIT(THR0),
        .FIFO_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sum       (sum),
        .thr_load  (thr_load),
        .thr_data  (thr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fire  (out_fire),
        .out_sum   (out_sum),
        .fire_count(fire_count),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: upstream sum schedule keyed by edge index, a queue for
    // the FIFO contents, and plain variables for the status.
    logic [47:0] sum_sched [int];
    logic [48:0] mq [$];
    logic        m_cap_v;
    logic [48:0] m_cap;
    logic [47:0] m_thr;
    logic [15:0] m_cnt;
    logic        m_ovf;

    typedef struct {
        logic [47:0] thr;
        logic [47:0] s;
        logic        fire;
        logic [15:0] cnt;
    } vec_t;

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_clear();
        mq.delete();
        sum_sched.delete();
        m_cap_v = 1'b0;
        m_cap   = '0;
        m_thr   = THR0;
        m_cnt   = '0;
        m_ovf   = 1'b0;
    endfunction

    task automatic tick(input bit iv, input logic [47:0] v, input bit tl,
                        input logic [47:0] td, input bit rdy);
        bit          pop;
        bit          ncv;
        logic [48:0] nc;
        nc        = '0;
        in_valid  = iv;
        thr_load  = tl;
        thr_data  = td;
        out_ready = rdy;
        if (iv) sum_sched[cyc + int'(L)] = v;
        if (sum_sched.exists(cyc)) sum = sum_sched[cyc];
        else sum = rnd48();
        @(posedge clk);
        pop = rdy && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (m_cap_v) begin
            if (mq.size() < D) begin
                mq.push_back(m_cap);
                if (m_cap[48] && m_cnt != 16'hFFFF) m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        ncv = sum_sched.exists(cyc);
        if (ncv) begin
            nc = {sum >= m_thr, sum};
            sum_sched.delete(cyc);
        end
        m_cap_v = ncv;
        m_cap   = nc;
        if (tl) m_thr = td;
        cyc++;
        #1;
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_fire", 64'(out_fire), 64'(mq[0][48]));
            chk("out_sum", 64'(out_sum), 64'(mq[0][47:0]));
        end
        chk("fire_count", 64'(fire_count), 64'(m_cnt));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("busy", 64'(busy), 64'(sum_sched.size() > 0 || m_cap_v || mq.size() > 0));
    endtask

    task automatic idle(input bit rdy);
        tick(1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            idle(1'b0);
            n++;
        end
        chk("wait_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    // Called between edges; resets asynchronously and checks outputs at once.
    task automatic reset_mid();
        rst       = 1'b1;
        in_valid  = 1'b0;
        thr_load  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_fire", 64'(out_fire), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_fire_count", 64'(fire_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        cyc += 2;
        rst = 1'b0;
    endtask

    initial begin
        vec_t        vec [8];
        int          n;
        logic [47:0] b [8];
        logic [47:0] got [$];
        int          first_idx;
        int          last_idx;
        logic [47:0] p [6];
        logic [47:0] f [5];
        logic [15:0] cnt_before;

        vec[0] = '{thr: 48'd100, s: 48'd100,      fire: 1'b1, cnt: 16'd1};
        vec[1] = '{thr: 48'd100, s: 48'd99,       fire: 1'b0, cnt: 16'd1};
        vec[2] = '{thr: 48'd0,   s: 48'd0,        fire: 1'b1, cnt: 16'd2};
        vec[3] = '{thr: MAXV,    s: MAXV,         fire: 1'b1, cnt: 16'd3};
        vec[4] = '{thr: MAXV,    s: MAXV - 48'd1, fire: 1'b0, cnt: 16'd3};
        vec[5] = '{thr: MSB,     s: MSB - 48'd1,  fire: 1'b0, cnt: 16'd3};
        vec[6] = '{thr: 48'd1,   s: MAXV,         fire: 1'b1, cnt: 16'd4};
        vec[7] = '{thr: MSB,     s: MSB,          fire: 1'b1, cnt: 16'd5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        sum       = '0;
        thr_load  = 1'b0;
        thr_data  = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_fire_count", 64'(fire_count), 64'd0);

        // Table-driven single vectors with end-to-end latency check.
        foreach (vec[i]) begin
            tick(1'b0, '0, 1'b1, vec[i].thr, 1'b0);
            tick(1'b1, vec[i].s, 1'b0, '0, 1'b0);
            wait_valid(n);
            chk("vec_latency", 64'(n), 64'(L + 1));
            chk("vec_fire", 64'(out_fire), 64'(vec[i].fire));
            chk("vec_sum", 64'(out_sum), 64'(vec[i].s));
            chk("vec_count", 64'(fire_count), 64'(vec[i].cnt));
            idle(1'b1);
        end

        // Threshold load on the capture edge uses the old threshold.
        tick(1'b0, '0, 1'b1, 48'd200, 1'b0);
        tick(1'b1, 48'd300, 1'b0, '0, 1'b0);
        repeat (L - 1) idle(1'b0);
        tick(1'b0, '0, 1'b1, 48'd500, 1'b0);
        wait_valid(n);
        chk("race_old_thr_fire", 64'(out_fire), 64'd1);
        idle(1'b1);
        tick(1'b1, 48'd300, 1'b0, '0, 1'b0);
        wait_valid(n);
        chk("race_new_thr_fire", 64'(out_fire), 64'd0);
        idle(1'b1);

        // Back-to-back with consumer always ready.
        got.delete();
        first_idx = -1;
        last_idx  = -1;
        for (int i = 0; i < 8; i++) begin
            b[i] = rnd48();
            tick(1'b1, b[i], 1'b0, '0, 1'b1);
        end
        for (int i = 0; i < 30; i++) begin
            idle(1'b1);
            if (out_valid) begin
                got.push_back(out_sum);
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
        end
        chk("b2b_count", 64'(got.size()), 64'd8);
        chk("b2b_consecutive", 64'(last_idx - first_idx), 64'd7);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) chk("b2b_order", 64'(got[i]), 64'(b[i]));
        end
        chk("b2b_overflow", 64'(overflow), 64'd0);

        // Reset in the middle of a stream with results buffered and in flight.
        tick(1'b0, '0, 1'b1, 48'd5, 1'b0);
        for (int i = 0; i < L + 3; i++) tick(1'b1, rnd48(), 1'b0, '0, 1'b0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        reset_mid();
        tick(1'b1, THR0, 1'b0, '0, 1'b0);
        wait_valid(n);
        chk("post_rst_latency", 64'(n), 64'(L + 1));
        chk("post_rst_fire", 64'(out_fire), 64'd1);
        chk("post_rst_sum", 64'(out_sum), 64'(THR0));
        idle(1'b1);
        tick(1'b1, THR0 - 48'd1, 1'b0, '0, 1'b0);
        wait_valid(n);
        chk("post_rst_thr_init", 64'(out_fire), 64'd0);
        idle(1'b1);

        // Full FIFO with a push and a pop on the same edge.
        for (int i = 0; i < 5; i++) begin
            f[i] = 48'd900 + 48'(i * 100);
            tick(1'b1, f[i], 1'b0, '0, 1'b0);
        end
        repeat (L) idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("full_pp_overflow", 64'(overflow), 64'd0);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            if (out_valid) got.push_back(out_sum);
            idle(1'b1);
        end
        chk("full_pp_occupancy", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("full_pp_order", 64'(got[i]), 64'(f[i + 1]));
        end

        // Backpressure: six results into a four-entry FIFO.
        p[0] = 48'd1000;
        p[1] = 48'd5;
        p[2] = 48'd2000;
        p[3] = 48'd999;
        p[4] = 48'd3000;
        p[5] = 48'd4000;
        cnt_before = m_cnt;
        for (int i = 0; i < 6; i++) tick(1'b1, p[i], 1'b0, '0, 1'b0);
        repeat (L + 4) idle(1'b0);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_fire_count", 64'(fire_count), 64'(cnt_before + 16'd2));
        got.delete();
        for (int i = 0; i < 10; i++) begin
            if (out_valid) got.push_back(out_sum);
            idle(1'b1);
        end
        chk("bp_drained", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("bp_order", 64'(got[i]), 64'(p[i]));
        end
        chk("bp_busy_low", 64'(busy), 64'd0);
        chk("bp_overflow_sticky", 64'(overflow), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [47:0] v;
            bit          tl;
            if ($urandom_range(0, 3) == 0) v = rnd48();
            else v = (m_thr + 48'($urandom_range(0, 6))) - 48'd3;
            tl = ($urandom_range(0, 19) == 0);
            tick(($urandom_range(0, 2) != 0), v, tl, 48'($urandom_range(0, 4000)),
                 ($urandom_range(0, 9) < 7));
        end
        repeat (L + 12) idle(1'b1);
        chk("final_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
